// File: rtl/i2s_serializer.sv
// I2S playback serializer: double-buffers a left/right sample pair and shifts it out MSB-first
// on DACDAT, re-timed to the codec-mastered BCLK/DACLRCK sampled in the CLOCK_50 domain.
module i2s_serializer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned UNDERRUN_ZERO = 0
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             BCLK,
  input  logic             DACLRCK,
  input  logic [WIDTH-1:0] leftSample,
  input  logic [WIDTH-1:0] rightSample,
  input  logic             sampleValid,
  output logic             DACDAT,
  output logic             frameReq,
  output logic             underrun,
  output logic             overrun
);

  localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic                   r_bclk_d;
  logic                   r_lrck_d;
  logic [SYNC_STAGES:0]   r_arm;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2*WIDTH-1:0]     r_shift;
  logic [2*WIDTH-1:0]     r_last;
  logic [WIDTH-1:0]       r_hold_l;
  logic [WIDTH-1:0]       r_hold_r;
  logic                   r_hold_full;

  logic                   w_armed;
  logic                   w_bclk_s;
  logic                   w_lrck_s;
  logic                   w_bfall;
  logic                   w_lrise;
  logic                   w_lfall;
  logic [CW-1:0]          w_cnt_m1;
  logic [WIDTH-1:0]       w_cur_word;
  logic [2*WIDTH-1:0]     w_load_val;

  // Edges are ignored until the synchronizer pipeline has refilled after reset, so a DACLRCK
  // that is already high at release does not look like a frame start.
  assign w_armed  = r_arm[SYNC_STAGES];
  assign w_bclk_s = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck_s = r_lrck_sync[SYNC_STAGES-1];
  assign w_bfall  = w_armed & r_bclk_d & ~w_bclk_s;
  assign w_lrise  = w_armed & ~r_lrck_d & w_lrck_s;
  assign w_lfall  = w_armed & r_lrck_d & ~w_lrck_s;

  assign w_cnt_m1   = r_cnt - 1'b1;
  assign w_cur_word = (r_state == ST_RIGHT) ? r_shift[WIDTH-1:0] : r_shift[2*WIDTH-1:WIDTH];
  assign w_load_val = r_hold_full ? {r_hold_l, r_hold_r} :
                      ((UNDERRUN_ZERO != 0) ? '0 : r_last);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_bclk_d    <= 1'b0;
      r_lrck_d    <= 1'b0;
      r_arm       <= '0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_last      <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
      DACDAT      <= 1'b0;
      frameReq    <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], BCLK};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], DACLRCK};
      r_bclk_d    <= w_bclk_s;
      r_lrck_d    <= w_lrck_s;
      r_arm       <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      frameReq    <= 1'b0;
      underrun    <= 1'b0;
      // A strobe that lands on a frame load does not lose data: the load drains the old pair.
      overrun     <= sampleValid & r_hold_full & ~w_lrise;

      if (sampleValid) begin
        r_hold_l    <= leftSample;
        r_hold_r    <= rightSample;
        r_hold_full <= 1'b1;
      end else if (w_lrise) begin
        r_hold_full <= 1'b0;
      end

      if (w_lrise) begin
        r_shift  <= w_load_val;
        frameReq <= 1'b1;
        underrun <= ~r_hold_full;
        DACDAT   <= w_load_val[2*WIDTH-1];
        r_cnt    <= CNT_MAX;
        r_state  <= ST_LEFT;
        if (r_hold_full) begin
          r_last <= w_load_val;
        end
      end else if (w_lfall && (r_state == ST_LEFT)) begin
        DACDAT  <= r_shift[WIDTH-1];
        r_cnt   <= CNT_MAX;
        r_state <= ST_RIGHT;
      end else if (w_bfall && (r_state != ST_IDLE)) begin
        if (r_cnt != '0) begin
          r_cnt  <= w_cnt_m1;
          DACDAT <= w_cur_word[w_cnt_m1];
        end else begin
          DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule
